// File: rtl/ifetch_queue.sv
// Instruction prefetch stage: fetches aligned 32-bit words and splits them into halfwords.
// A 4-entry halfword queue feeds the 16-bit decoder one instruction per cycle.
module ifetch_queue #(
  parameter int              RV       = 32,
  parameter logic [RV-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          advance,
  input  logic          redirect,
  input  logic [RV-1:0] redirect_pc,
  output logic          imem_req,
  output logic [RV-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  output logic [15:0]   ins,
  output logic [RV-1:0] ins_pc,
  output logic          idone
);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  localparam logic [RV-1:0] WORD_MASK = {{(RV-2){1'b1}}, 2'b00};
  localparam logic [RV-1:0] HW_MASK   = {{(RV-1){1'b1}}, 1'b0};
  localparam logic [RV-1:0] PC_STEP   = {{(RV-2){1'b0}}, 2'b10};
  localparam logic [RV-1:0] WORD_STEP = {{(RV-3){1'b0}}, 3'b100};

  state_t        state;
  logic [15:0]   q [4];
  logic [1:0]    head;
  logic [1:0]    tail;
  logic [2:0]    count;
  logic [RV-1:0] fetch_pc;
  logic [RV-1:0] head_pc;
  logic          skip;
  logic          push_ok;
  logic [2:0]    push_n;

  // A DROP request still occupies the bus, so imem_req covers both waiting states.
  assign imem_req = (state != IDLE);
  assign idone    = (count != 3'd0) & advance & ~redirect;
  assign ins      = q[head];
  assign ins_pc   = head_pc;
  assign push_ok  = (state == WAIT) & imem_ack & ~redirect;
  assign push_n   = push_ok ? (skip ? 3'd1 : 3'd2) : 3'd0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      head      <= 2'd0;
      tail      <= 2'd0;
      count     <= 3'd0;
      fetch_pc  <= RESET_PC & WORD_MASK;
      skip      <= RESET_PC[1];
      head_pc   <= RESET_PC;
      imem_addr <= '0;
    end else if (redirect) begin
      head     <= 2'd0;
      tail     <= 2'd0;
      count    <= 3'd0;
      fetch_pc <= redirect_pc & WORD_MASK;
      skip     <= redirect_pc[1];
      head_pc  <= redirect_pc & HW_MASK;
      // An in-flight request must still be completed on the bus; an ack now ends it.
      if (state != IDLE) begin
        state <= imem_ack ? IDLE : DROP;
      end
    end else begin
      count <= count + push_n - {2'b00, idone};
      if (idone) begin
        head    <= head + 2'd1;
        head_pc <= head_pc + PC_STEP;
      end
      if (push_ok) begin
        if (skip) begin
          q[tail] <= imem_rdata[31:16];
          tail    <= tail + 2'd1;
          skip    <= 1'b0;
        end else begin
          q[tail]        <= imem_rdata[15:0];
          q[tail + 2'd1] <= imem_rdata[31:16];
          tail           <= tail + 2'd2;
        end
        fetch_pc <= fetch_pc + WORD_STEP;
      end
      // Issuing only at count<=2 leaves room for a full two-halfword push.
      case (state)
        IDLE: begin
          if (count <= 3'd2) begin
            state     <= WAIT;
            imem_addr <= fetch_pc;
          end
        end
        WAIT, DROP: begin
          if (imem_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: transaction-level model of the halfword stream,
// queue occupancy and request protocol, plus directed scenario tasks.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        advance = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [15:0] ins;
  logic [31:0] ins_pc;
  logic        idone;

  int checks = 0;
  int errors = 0;

  ifetch_queue #(.RV(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .advance(advance), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ins(ins), .ins_pc(ins_pc),
    .idone(idone)
  );

  always #5 clk = ~clk;

  // Memory image: the halfword stored at byte address a is a/2.
  function automatic logic [15:0] hw(input logic [31:0] a);
    return a[16:1];
  endfunction

  // Memory responder: acks after cur_lat extra cycles of a held request.
  int mem_lat = 0;
  int cur_lat = 0;
  int mem_cnt = 0;
  bit mem_rand = 1'b0;

  always @(posedge clk) begin
    #1;
    if (imem_req !== 1'b1) begin
      imem_ack = 1'b0;
      mem_cnt  = 0;
    end else if (mem_cnt >= cur_lat) begin
      imem_ack   = 1'b1;
      imem_rdata = {hw(imem_addr + 32'd2), hw(imem_addr)};
      mem_cnt    = 0;
      cur_lat    = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
    end else begin
      imem_ack = 1'b0;
      mem_cnt++;
    end
  end

  // Reference model: next pc to present, end of fetched stream, next fetch address.
  logic [31:0] exp_pc, fill_end, exp_fetch, hold_addr;
  bit          exp_req = 1'b0, exp_rise = 1'b0, pend_drop = 1'b0, model_ok = 1'b0;
  bit          prev_req = 1'b0;
  int          idone_cnt = 0;
  int          req_rises = 0;
  logic [31:0] seen_pc[$];
  logic [15:0] seen_ins[$];

  always @(negedge clk) begin
    logic [31:0] occ;
    bit          exp_idone, nreq;
    occ       = (fill_end - exp_pc) >> 1;
    exp_idone = (occ != 0) && advance && !redirect;
    if (model_ok) begin
      checks++;
      if (imem_req !== exp_req) begin
        errors++;
        $display("[TB] FAIL req_protocol t=%0t actual=%b required=%b", $time, imem_req, exp_req);
      end
      checks++;
      if (idone !== exp_idone) begin
        errors++;
        $display("[TB] FAIL idone_rule t=%0t actual=%b required=%b (occupancy %0d)", $time, idone, exp_idone, occ);
      end
      if (exp_idone) begin
        checks++;
        if (ins_pc !== exp_pc || ins !== hw(exp_pc)) begin
          errors++;
          $display("[TB] FAIL stream t=%0t actual pc=%h ins=%h required pc=%h ins=%h", $time, ins_pc, ins, exp_pc, hw(exp_pc));
        end
      end
      if (exp_req) begin
        if (exp_rise) hold_addr = exp_fetch;
        checks++;
        if (imem_addr !== hold_addr) begin
          errors++;
          $display("[TB] FAIL imem_addr t=%0t actual=%h required=%h", $time, imem_addr, hold_addr);
        end
      end
    end
    if (idone === 1'b1) begin
      idone_cnt++;
      seen_pc.push_back(ins_pc);
      seen_ins.push_back(ins);
    end
    if (imem_req === 1'b1 && !prev_req) req_rises++;
    prev_req = (imem_req === 1'b1);

    nreq = exp_req ? !(imem_ack === 1'b1) : (!redirect && occ <= 2);
    if (exp_idone) exp_pc = exp_pc + 32'd2;
    if (exp_req && imem_ack === 1'b1) begin
      if (!pend_drop && !redirect) begin
        fill_end  = exp_fetch + 32'd4;
        exp_fetch = exp_fetch + 32'd4;
      end
      pend_drop = 1'b0;
    end
    if (redirect) begin
      exp_pc    = redirect_pc & ~32'd1;
      fill_end  = exp_pc;
      exp_fetch = redirect_pc & ~32'd3;
      if (exp_req && imem_ack !== 1'b1) pend_drop = 1'b1;
    end
    exp_rise = nreq && !exp_req;
    exp_req  = nreq;
    if (reset === 1'b0) begin
      exp_pc    = 32'h0;
      fill_end  = 32'h0;
      exp_fetch = 32'h0;
      pend_drop = 1'b0;
      exp_req   = 1'b0;
      exp_rise  = 1'b0;
      model_ok  = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_lat(input int n);
    mem_lat  = n;
    cur_lat  = n;
    mem_rand = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    advance = 1'b1;
    do_reset();
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_req actual=%b required=0", imem_req);
    end
    checks++;
    if (idone !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idone actual=%b required=0", idone);
    end
  endtask

  task automatic test_stream();
    set_lat(0);
    advance = 1'b0;
    do_reset();
    seen_pc.delete();
    seen_ins.delete();
    advance = 1'b1;
    repeat (40) tick();
    checks++;
    if (seen_pc.size() < 8) begin
      errors++;
      $display("[TB] FAIL stream_count actual=%0d required>=8", seen_pc.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (seen_pc[i] !== 32'(2 * i) || seen_ins[i] !== 16'(i)) begin
          errors++;
          $display("[TB] FAIL stream_seq[%0d] actual pc=%h ins=%h required pc=%h ins=%h", i, seen_pc[i], seen_ins[i], 32'(2 * i), 16'(i));
        end
      end
    end
    advance = 1'b0;
  endtask

  task automatic test_stall();
    set_lat(0);
    advance = 1'b0;
    do_reset();
    req_rises = 0;
    repeat (20) tick();
    checks++;
    if (req_rises !== 2) begin
      errors++;
      $display("[TB] FAIL stall_requests actual=%0d required=2", req_rises);
    end
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_req_idle actual=%b required=0", imem_req);
    end
    tick();
    advance = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (idone !== 1'b1) begin
        errors++;
        $display("[TB] FAIL back_to_back[%0d] actual=%b required=1", i, idone);
      end
      tick();
    end
    advance = 1'b0;
  endtask

  task automatic test_redirect_queue();
    bit found = 1'b0;
    set_lat(0);
    advance = 1'b0;
    do_reset();
    repeat (12) tick();
    advance = 1'b1;
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h102;
    @(negedge clk);
    checks++;
    if (idone !== 1'b0) begin
      errors++;
      $display("[TB] FAIL redirect_q_idone actual=%b required=0", idone);
    end
    tick();
    redirect = 1'b0;
    seen_pc.delete();
    seen_ins.delete();
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (seen_pc.size() >= 2) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL redirect_q_timeout actual=%0d idones required=2", seen_pc.size());
    end else if (seen_pc[0] !== 32'h102 || seen_ins[0] !== 16'h81 || seen_pc[1] !== 32'h104) begin
      errors++;
      $display("[TB] FAIL redirect_q_first actual pc=%h ins=%h next=%h required pc=102 ins=0081 next=104", seen_pc[0], seen_ins[0], seen_pc[1]);
    end
    advance = 1'b0;
  endtask

  task automatic test_redirect_wait();
    bit up = 1'b0, got = 1'b0, held = 1'b1;
    set_lat(5);
    advance = 1'b0;
    do_reset();
    for (int i = 0; i < 10 && !up; i++) begin
      tick();
      if (imem_req === 1'b1) up = 1'b1;
    end
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      if (imem_ack === 1'b1) got = 1'b1;
      else if (imem_req !== 1'b1) held = 1'b0;
      if (!got) tick();
    end
    checks++;
    if (!up || !got || !held) begin
      errors++;
      $display("[TB] FAIL drop_hold actual up=%b ack=%b held=%b required 1 1 1", up, got, held);
    end
    up = 1'b0;
    tick();
    for (int i = 0; i < 10 && !up; i++) begin
      tick();
      if (imem_req === 1'b1) up = 1'b1;
    end
    checks++;
    if (!up || imem_addr !== 32'h200) begin
      errors++;
      $display("[TB] FAIL drop_refetch actual req=%b addr=%h required req=1 addr=00000200", up, imem_addr);
    end
  endtask

  task automatic test_redirect_ack();
    int  acks = 0;
    bit  found = 1'b0;
    set_lat(2);
    advance = 1'b0;
    do_reset();
    for (int i = 0; i < 30 && acks < 2; i++) begin
      tick();
      if (imem_ack === 1'b1) acks++;
    end
    advance     = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h344;
    @(negedge clk);
    checks++;
    if (acks != 2 || idone !== 1'b0) begin
      errors++;
      $display("[TB] FAIL redirect_ack_idone actual acks=%0d idone=%b required acks=2 idone=0", acks, idone);
    end
    tick();
    redirect = 1'b0;
    seen_pc.delete();
    seen_ins.delete();
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (seen_pc.size() >= 1) found = 1'b1;
    end
    checks++;
    if (!found || seen_pc[0] !== 32'h344 || seen_ins[0] !== hw(32'h344)) begin
      errors++;
      $display("[TB] FAIL redirect_ack_refetch actual found=%b pc=%h required pc=00000344", found, found ? seen_pc[0] : 32'h0);
    end
    advance = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    bit got = 1'b0, up = 1'b0;
    set_lat(5);
    advance = 1'b0;
    do_reset();
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (imem_ack === 1'b1) got = 1'b1;
    end
    for (int i = 0; i < 10 && !up; i++) begin
      tick();
      if (imem_req === 1'b1 && imem_ack !== 1'b1) up = 1'b1;
    end
    tick();
    advance = 1'b1;
    reset   = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (!got || !up || imem_req !== 1'b0 || idone !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_wait actual setup=%b%b req=%b idone=%b required setup=11 req=0 idone=0", got, up, imem_req, idone);
    end
    up = 1'b0;
    for (int i = 0; i < 10 && !up; i++) begin
      tick();
      if (imem_req === 1'b1) up = 1'b1;
    end
    checks++;
    if (!up || imem_addr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_refetch actual req=%b addr=%h required req=1 addr=00000000", up, imem_addr);
    end
    advance = 1'b0;
  endtask

  task automatic test_random();
    int start;
    set_lat(0);
    mem_rand = 1'b1;
    do_reset();
    start = idone_cnt;
    for (int i = 0; i < 1500; i++) begin
      advance  = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      else                           redirect_pc = $urandom & 32'h0000_FFFF;
      tick();
    end
    redirect = 1'b0;
    advance  = 1'b0;
    mem_rand = 1'b0;
    checks++;
    if (idone_cnt - start < 100) begin
      errors++;
      $display("[TB] FAIL random_progress actual=%0d idones required>=100", idone_cnt - start);
    end
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_queue();
    test_redirect_wait();
    test_redirect_ack();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
